// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the fetch/decode/execute sequencer.
//   seq_state_t      - sequencer FSM states
//   OP_HALT/OP_JUMP  - control opcodes matched on instruction bits [OP_MSB:OP_LSB]
//   JT_MSB/JT_LSB    - in-line jump target field
//   *_DEFAULT        - default widths for pipeline_sequencer
package pipeline_pkg;

  localparam int unsigned PC_W_DEFAULT    = 5;
  localparam int unsigned INSTR_W_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT   = 16;

  localparam int unsigned OP_MSB = 16;
  localparam int unsigned OP_LSB = 0;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;

  localparam int unsigned JT_MSB = 31;
  localparam int unsigned JT_LSB = 27;

  localparam logic [OP_W-1:0] OP_HALT = 17'h1FFFF;
  localparam logic [OP_W-1:0] OP_JUMP = 17'b10000001101010101;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StIssue,
    StHalt
  } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: owns the PC, reads instruction words from a synchronous
// instruction memory and hands them to decode over a valid/ready handshake.
// Resolves in-line JUMP/HALT opcodes and accepts redirects from execute.
//   clk, reset (async, active-high)
//   start, start_pc          - begin execution (accepted in IDLE/HALT only)
//   imem_rd_en, imem_addr    - read strobe/address, data returns next cycle
//   imem_rdata               - instruction read data
//   dec_valid/ready/instr/pc - decode handshake, registered outputs
//   ex_redirect, ex_target   - PC redirect from execute (FETCH/LOAD/ISSUE only)
//   busy, halted             - registered state decodes
//   issue_count              - completed decode handshakes, wraps
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEFAULT,
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    start_pc,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  input  logic               ex_redirect,
  input  logic [PC_W-1:0]    ex_target,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   issue_count
);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               dec_valid_q, dec_valid_d;
  logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
  logic [PC_W-1:0]    dec_pc_q, dec_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;

  logic [OP_W-1:0] opcode;
  logic [PC_W-1:0] jump_target;
  logic            handshake;

  assign opcode      = dec_instr_q[OP_MSB:OP_LSB];
  assign jump_target = PC_W'(dec_instr_q[JT_MSB:JT_LSB]);
  assign handshake   = (state_q == StIssue) && dec_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      dec_valid_q <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state and next-PC mux
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_valid_d = dec_valid_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        dec_instr_d = imem_rdata;
        dec_pc_d    = pc_q;
        dec_valid_d = 1'b1;
        state_d     = StIssue;
      end
      StIssue: begin
        if (handshake) begin
          dec_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          if (opcode == OP_HALT) begin
            state_d = StHalt;
          end else if (opcode == OP_JUMP) begin
            pc_d    = jump_target;
            state_d = StFetch;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect wins over the opcode decode; a handshake in the same cycle still counts.
    if (ex_redirect && (state_q inside {StFetch, StLoad, StIssue})) begin
      pc_d        = ex_target;
      dec_valid_d = 1'b0;
      state_d     = StFetch;
    end

    busy_d   = state_d inside {StFetch, StLoad, StIssue};
    halted_d = (state_d == StHalt);
  end

  // Outputs
  always_comb begin
    imem_rd_en  = (state_q == StFetch);
    imem_addr   = pc_q;
    dec_valid   = dec_valid_q;
    dec_instr   = dec_instr_q;
    dec_pc      = dec_pc_q;
    busy        = busy_q;
    halted      = halted_q;
    issue_count = cnt_q;
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer. The stimulus side runs a
// program-level model (next PC from opcode/redirect) and queues the expected
// handshake stream; a negedge monitor compares every presented word.
module tb_pipeline_sequencer;

  localparam logic [16:0] HALT_OP = 17'h1FFFF;
  localparam logic [16:0] JUMP_OP = 17'b10000001101010101;

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] instr;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  start_pc = '0;
  logic        imem_rd_en;
  logic [4:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [4:0]  dec_pc;
  logic        ex_redirect = 1'b0;
  logic [4:0]  ex_target = '0;
  logic        busy;
  logic        halted;
  logic [15:0] issue_count;

  logic [31:0] mem [32];
  item_t       exp_q [$];
  item_t       model_cur;
  int          model_cnt = 0;
  bit          model_halted = 0;
  int          checks = 0;
  int          errors = 0;
  int          mon_cnt = 0;
  int          rd_count = 0;

  pipeline_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_pc   (start_pc),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .ex_redirect(ex_redirect),
    .ex_target  (ex_target),
    .busy       (busy),
    .halted     (halted),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its bound (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mk_word(input int kind, input logic [4:0] tgt);
    logic [31:0] w;
    w = $urandom;
    if (kind == 1) begin
      w[16:0] = HALT_OP;
    end else if (kind == 2) begin
      w[31:27] = tgt;
      w[16:0]  = JUMP_OP;
    end else if (w[16:0] == HALT_OP || w[16:0] == JUMP_OP) begin
      w[0] = ~w[0];
    end
    return w;
  endfunction

  task automatic push(input logic [4:0] pc);
    model_cur = '{pc: pc, instr: mem[pc]};
    exp_q.push_back(model_cur);
  endtask

  // Program-level model: decide what decode sees next for this cycle's inputs.
  task automatic model_cycle();
    if (!reset && dec_valid) begin
      if (dec_ready) begin
        model_cnt++;
        if (ex_redirect) push(ex_target);
        else if (model_cur.instr[16:0] == HALT_OP) model_halted = 1;
        else if (model_cur.instr[16:0] == JUMP_OP) push(model_cur.instr[31:27]);
        else push(model_cur.pc + 5'd1);
      end else if (ex_redirect) begin
        push(ex_target);
      end
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] pc);
    start    = 1'b1;
    start_pc = pc;
    step();
    start        = 1'b0;
    model_halted = 0;
    push(pc);
  endtask

  task automatic run_to_halt(input int budget, input string name);
    int n = 0;
    while (!model_halted && n < budget) begin
      step();
      n++;
    end
    if (!model_halted) fail({name, "_halt_timeout"});
    step();
    check({name, "_halted"}, 64'(halted), 64'(1));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_issue_count"}, 64'(issue_count), 64'(16'(model_cnt)));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic apply_reset(input string name);
    reset = 1'b1;
    #2;
    check({name, "_dec_valid"}, 64'(dec_valid), 64'(0));
    check({name, "_dec_instr"}, 64'(dec_instr), 64'(0));
    check({name, "_dec_pc"}, 64'(dec_pc), 64'(0));
    check({name, "_imem_rd_en"}, 64'(imem_rd_en), 64'(0));
    check({name, "_imem_addr"}, 64'(imem_addr), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_halted"}, 64'(halted), 64'(0));
    check({name, "_issue_count"}, 64'(issue_count), 64'(0));
    exp_q.delete();
    model_cnt    = 0;
    model_halted = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare every presented word, pop on handshake or redirect-discard.
  always @(negedge clk) begin
    if (reset) begin
      mon_cnt = 0;
    end else begin
      if (imem_rd_en) rd_count++;
      check("busy_halted_exclusive", 64'(busy & halted), 64'(0));
      if (dec_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_dec_valid");
        end else begin
          check("dec_pc", 64'(dec_pc), 64'(exp_q[0].pc));
          check("dec_instr", 64'(dec_instr), 64'(exp_q[0].instr));
          if (dec_ready || ex_redirect) void'(exp_q.pop_front());
        end
        if (dec_ready) begin
          check("issue_count_at_handshake", 64'(issue_count), 64'(16'(mon_cnt)));
          mon_cnt++;
        end
      end
    end
  end

  initial begin
    int rd0;
    int idle;
    for (int i = 0; i < 32; i++) mem[i] = mk_word(0, '0);

    apply_reset("reset");

    // Straight-line: 0,1,2 then HALT at 3, one word every 3 cycles
    mem[3]    = mk_word(1, '0);
    dec_ready = 1'b1;
    rd0       = rd_count;
    do_start(5'd0);
    check("sl_fetch_rd_en", 64'(imem_rd_en), 64'(1));
    check("sl_fetch_addr", 64'(imem_addr), 64'(0));
    check("sl_fetch_busy", 64'(busy), 64'(1));
    step();
    check("sl_load_rd_en", 64'(imem_rd_en), 64'(0));
    check("sl_load_valid", 64'(dec_valid), 64'(0));
    step();
    check("sl_first_valid", 64'(dec_valid), 64'(1));
    for (int i = 1; i <= 9; i++) begin
      step();
      check("sl_throughput_valid", 64'(dec_valid), 64'((i % 3) == 0));
    end
    run_to_halt(10, "sl");
    check("sl_issue_count_4", 64'(issue_count), 64'(4));
    check("sl_read_count", 64'(rd_count - rd0), 64'(4));

    // Jump: 0,1,2 -> 9,10(HALT)
    mem[2]  = mk_word(2, 5'd9);
    mem[10] = mk_word(1, '0);
    do_start(5'd0);
    run_to_halt(40, "jump");

    // Back-pressure: 5-cycle stall in ISSUE
    mem[6]    = mk_word(1, '0);
    dec_ready = 1'b0;
    do_start(5'd5);
    step();
    step();
    check("bp_valid", 64'(dec_valid), 64'(1));
    rd0 = rd_count;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", 64'(dec_valid), 64'(1));
      check("bp_hold_instr", 64'(dec_instr), 64'(mem[5]));
      check("bp_hold_count", 64'(issue_count), 64'(16'(model_cnt)));
    end
    check("bp_no_extra_read", 64'(rd_count - rd0), 64'(0));
    dec_ready = 1'b1;
    run_to_halt(20, "bp");

    // Redirect during LOAD discards the in-flight word
    mem[20] = mk_word(1, '0);
    do_start(5'd0);
    step();
    ex_redirect = 1'b1;
    ex_target   = 5'd20;
    exp_q.delete();
    push(5'd20);
    step();
    ex_redirect = 1'b0;
    check("rd_fetch_rd_en", 64'(imem_rd_en), 64'(1));
    check("rd_fetch_addr", 64'(imem_addr), 64'(20));
    run_to_halt(20, "rd");

    // Redirect on the handshake of a HALT word overrides the halt
    mem[11] = mk_word(1, '0);
    mem[25] = mk_word(1, '0);
    do_start(5'd11);
    step();
    step();
    ex_redirect = 1'b1;
    ex_target   = 5'd25;
    step();
    ex_redirect = 1'b0;
    run_to_halt(20, "rd_hs");

    // PC wrap 31 -> 0
    mem[31] = mk_word(0, '0);
    mem[0]  = mk_word(1, '0);
    do_start(5'd31);
    run_to_halt(20, "wrap");

    // Redirect in HALT is ignored
    rd0         = rd_count;
    ex_redirect = 1'b1;
    ex_target   = 5'd7;
    step();
    ex_redirect = 1'b0;
    step();
    step();
    check("halt_redirect_ignored", 64'(halted), 64'(1));
    check("halt_no_read", 64'(rd_count - rd0), 64'(0));

    // Reset while in ISSUE
    dec_ready = 1'b0;
    do_start(5'd31);
    step();
    step();
    check("midrst_valid_before", 64'(dec_valid), 64'(1));
    apply_reset("midrst");

    // Randomized program with random back-pressure, redirects and ignored starts
    for (int i = 0; i < 32; i++) begin
      int r;
      r = $urandom_range(0, 99);
      mem[i] = mk_word((r < 8) ? 1 : ((r < 20) ? 2 : 0), 5'($urandom_range(0, 31)));
    end
    idle = 0;
    do_start(5'($urandom_range(0, 31)));
    for (int c = 0; c < 4000; c++) begin
      if (model_halted) begin
        check("rand_halted", 64'(halted), 64'(1));
        check("rand_halt_count", 64'(issue_count), 64'(16'(model_cnt)));
        check("rand_halt_queue", 64'(exp_q.size()), 64'(0));
        do_start(5'($urandom_range(0, 31)));
        idle = 0;
        continue;
      end
      dec_ready   = ($urandom_range(0, 99) < 60);
      ex_redirect = dec_valid && ($urandom_range(0, 99) < 8);
      ex_target   = 5'($urandom_range(0, 31));
      start       = dec_valid && ($urandom_range(0, 99) < 3);
      start_pc    = 5'($urandom_range(0, 31));
      if (dec_valid) idle = 0;
      else idle++;
      if (idle > 10) begin
        fail("rand_watchdog");
        break;
      end
      step();
      ex_redirect = 1'b0;
      start       = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequencer for the fetch → decode → execute pipeline. It owns the program counter, reads 32-bit instruction words from a synchronous 32-entry instruction memory, and presents each word to the decode stage over a valid/ready handshake. It resolves in-line jumps and halts itself, and it accepts redirects from the execute stage. It sits between the instruction store and `decode`, replacing free-running instruction readout.

## Interface
- `PC_W`, default 5: program counter and instruction-address width (32 entries).
- `INSTR_W`, default 32: instruction word width.
- `CNT_W`, default 16: issue counter width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle pulse; begins execution at `start_pc`.
- `start_pc`  in  PC_W  entry address, sampled with `start`.
- `imem_rd_en`  out  1  instruction memory read strobe.
- `imem_addr`  out  PC_W  instruction memory address.
- `imem_rdata`  in  INSTR_W  read data, valid the cycle after the read strobe.
- `dec_valid`  out  1  `dec_instr`/`dec_pc` hold a valid instruction.
- `dec_ready`  in  1  decode accepts when high together with `dec_valid`.
- `dec_instr`  out  INSTR_W  instruction word to decode.
- `dec_pc`  out  PC_W  address of `dec_instr`.
- `ex_redirect`  in  1  execute requests a PC change; pulse.
- `ex_target`  in  PC_W  redirect target.
- `busy`  out  1  high in FETCH, LOAD and ISSUE.
- `halted`  out  1  high in HALT.
- `issue_count`  out  CNT_W  count of completed decode handshakes; wraps.

## Operation
- The sequencer uses the states IDLE, FETCH, LOAD, ISSUE and HALT.
- **IDLE:** the state after reset. On `start`, load `pc = start_pc` and go to FETCH.
- **FETCH:** drive `imem_rd_en = 1` and `imem_addr = pc`, then go to LOAD.
- **LOAD:**
  - `imem_rdata` is valid in this cycle.
  - On the closing edge, register `dec_instr = imem_rdata` and `dec_pc = pc`, set `dec_valid`, and go to ISSUE.
- **ISSUE:**
  - Hold `dec_valid`, `dec_instr` and `dec_pc` stable until `dec_ready`.
  - On the handshake, clear `dec_valid` and increment `issue_count`.
  - Choose the next state from opcode bits [16:0]:
    - `OP_HALT` (17'h1FFFF): go to HALT.
    - `OP_JUMP` (17'b10000001101010101): set `pc = instr[31:27]` and go to FETCH.
    - Any other opcode: set `pc = pc + 1`, wrapping modulo 2^PC_W, and go to FETCH.
- **HALT:** idle until `start`, which behaves as it does in IDLE.
- **Redirect:**
  - In FETCH, LOAD or ISSUE, `ex_redirect` sets `pc = ex_target`, clears `dec_valid` and goes to FETCH.
  - Any in-flight read is discarded.
- **Redirect on the handshake cycle:** if `ex_redirect` arrives in the same cycle as an ISSUE handshake:
  - The handshake counts: `issue_count` increments.
  - The redirect target overrides both JUMP and HALT decoding.
- **Ignored events:**
  - `start` is ignored in FETCH, LOAD and ISSUE.
  - `ex_redirect` is ignored in IDLE and HALT.

## Timing
- Reset values:
  - state IDLE; `pc` 0.
  - `imem_rd_en` 0; `imem_addr` 0.
  - `dec_valid` 0; `dec_instr` 0; `dec_pc` 0.
  - `busy` 0; `halted` 0; `issue_count` 0.
- `start` at edge N: FETCH in cycle N+1, LOAD in cycle N+2, `dec_valid` high from cycle N+3.
- Throughput is one instruction per 3 cycles when `dec_ready` is held high.
- A back-pressure stall of k cycles extends ISSUE by k cycles; the outputs do not change during the stall.
- A redirect takes effect at the next edge: FETCH of `ex_target` one cycle later, `dec_valid` three cycles later.
- `imem_rd_en` is high only in FETCH: exactly one read per fetched instruction.
- `busy` and `halted` are registered state decodes.
- `busy` and `halted` are mutually exclusive and both low in IDLE.
- Reset asserted mid-operation returns every output to its reset value immediately.
- `issue_count` wraps from 2^CNT_W−1 to 0.

## Structure
- Package `pipeline_pkg` holds:
  - the state enum `seq_state_t`;
  - the constants `OP_HALT` and `OP_JUMP`, and the opcode field bounds [16:0];
  - the jump-target field bounds [31:27];
  - the width defaults.
- The block is a single module: a registered FSM plus the next-PC mux. No sub-module.

## Test plan
- **Straight-line run:** `start` with `start_pc = 0`, mem[0..2] non-control and mem[3] = HALT, `dec_ready = 1` → `dec_pc` sequence 0,1,2,3, each `dec_valid` 3 cycles apart; then `halted = 1` and `issue_count = 4`.
- **Jump:** mem[2] = {5'd9, 10'b0, OP_JUMP} → after `dec_pc = 2`, the next `dec_pc` is 9.
- **Back-pressure:** hold `dec_ready = 0` for 5 cycles in ISSUE → `dec_instr` stays stable, no extra `imem_rd_en`, and `issue_count` increments only once.
- **Redirect:** pulse `ex_redirect` with `ex_target = 20` during LOAD → no handshake for the in-flight word, FETCH drives `imem_addr = 20` the next cycle, then `dec_pc = 20`.
- **Wrap and mid-run reset:** `start_pc = 31` with a non-control instruction → next `dec_pc = 0`. Assert `reset` while in ISSUE → `dec_valid` 0, `pc` 0, `issue_count` 0, state IDLE.
